// File: rtl/pe_output_collector_if.sv
// Handshake bundle between the depthwise PE, the collector and the output buffer.
// slave = collector side, master = the PE / buffer side that drives it.
interface pe_output_collector_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_addr;
    logic signed [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/pe_output_collector.sv
// Sums CHANNELS signed PE results per pixel, saturates / ReLUs the sum and
// writes it to the output buffer at an auto-incrementing address.
module pe_output_collector #(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 24,
    parameter int CHANNELS   = 3,
    parameter int NUM_PIXELS = 1024,
    parameter int ADDR_W     = 10,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    pe_output_collector_if.slave  bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sat_flag_o
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CH_W-1:0]          ch_cnt_q;
    logic [ADDR_W-1:0]        pix_cnt_q;
    logic [ADDR_W-1:0]        out_addr_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic                     sat_q;

    logic                     in_hs, out_hs, last_ch, last_pix, sat_hi, sat_lo;
    logic signed [ACC_W-1:0]  sum;
    logic signed [DATA_W-1:0] clip, pix;

    assign in_hs    = bus.in_valid & bus.in_ready;
    assign out_hs   = bus.out_valid & bus.out_ready;
    assign last_ch  = (ch_cnt_q == CH_W'(CHANNELS-1));
    assign last_pix = (pix_cnt_q == ADDR_W'(NUM_PIXELS-1));

    // The wide accumulator cannot wrap, so clamping happens once on the final sum.
    assign sum    = acc_q + {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
    assign sat_hi = (sum > SAT_MAX);
    assign sat_lo = (sum < SAT_MIN);
    assign clip   = sat_hi ? SAT_MAX[DATA_W-1:0] :
                    sat_lo ? SAT_MIN[DATA_W-1:0] : sum[DATA_W-1:0];
    assign pix    = (RELU_EN && clip[DATA_W-1]) ? '0 : clip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = ACCUM;
            ACCUM:   if (in_hs && last_ch) state_d = EMIT;
            EMIT:    if (out_hs) state_d = last_pix ? DONE : ACCUM;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ACCUM);
        bus.out_valid = (state_q == EMIT);
        busy_o        = (state_q == ACCUM) || (state_q == EMIT);
        done_o        = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            ch_cnt_q   <= '0;
            pix_cnt_q  <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (start_i) begin
                    acc_q     <= '0;
                    ch_cnt_q  <= '0;
                    pix_cnt_q <= '0;
                    sat_q     <= 1'b0;
                end
                ACCUM: if (in_hs) begin
                    if (last_ch) begin
                        out_data_q <= pix;
                        out_addr_q <= pix_cnt_q;
                        acc_q      <= '0;
                        ch_cnt_q   <= '0;
                        if (sat_hi || sat_lo) sat_q <= 1'b1;
                    end else begin
                        acc_q    <= sum;
                        ch_cnt_q <= ch_cnt_q + CH_W'(1);
                    end
                end
                // Address stays at the last pixel; there is no wrap inside a frame.
                EMIT: if (out_hs && !last_pix) pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.out_addr = out_addr_q;
    assign bus.out_data = out_data_q;
    assign sat_flag_o   = sat_q;
endmodule

// File: tb/tb_pe_output_collector.sv
// Directed bench: two collectors (ReLU on / off) share one stimulus stream and
// their pixel writes are checked against hand-computed sums.
module tb_pe_output_collector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b1;
    logic        busy0, done0, sat0, busy1, done1, sat1;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [1:0]  wa_q[$];
    logic [15:0] wd0_q[$];
    logic [15:0] wd1_q[$];
    logic [15:0] vals[12];
    logic [15:0] exp0[4];
    logic [15:0] exp1[4];

    always #5 clk = ~clk;

    pe_output_collector_if #(.DATA_W(16), .ADDR_W(2)) if0 ();
    pe_output_collector_if #(.DATA_W(16), .ADDR_W(2)) if1 ();

    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.out_ready = out_ready;
    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready;

    pe_output_collector #(.DATA_W(16), .ACC_W(24), .CHANNELS(3), .NUM_PIXELS(4),
                          .ADDR_W(2), .RELU_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst_n), .start_i(start), .bus(if0),
        .busy_o(busy0), .done_o(done0), .sat_flag_o(sat0));

    pe_output_collector #(.DATA_W(16), .ACC_W(24), .CHANNELS(3), .NUM_PIXELS(4),
                          .ADDR_W(2), .RELU_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst_n), .start_i(start), .bus(if1),
        .busy_o(busy1), .done_o(done1), .sat_flag_o(sat1));

    // Write port watcher: a handshake seen mid-cycle completes at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if0.out_valid && out_ready) begin
                wa_q.push_back(if0.out_addr);
                wd0_q.push_back(if0.out_data);
                wd1_q.push_back(if1.out_data);
            end
            if (done0) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete(); wd0_q.delete(); wd1_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [15:0] v, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = v;
        do begin @(negedge clk); n++; end while (!if0.in_ready && n < 200);
        if (!if0.in_ready) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done0 && n < 500);
        check($sformatf("%s_done", name), done0, 1);
        check($sformatf("%s_busy_at_done", name), busy0, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input string name, input logic s0, input logic s1);
        check($sformatf("%s_nwr", name), wa_q.size(), 4);
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), wa_q[i], i);
            check($sformatf("%s_relu_data%0d", name, i), wd0_q[i], exp0[i]);
            check($sformatf("%s_raw_data%0d", name, i), wd1_q[i], exp1[i]);
        end
        check($sformatf("%s_ndone", name), done_cnt, 1);
        check($sformatf("%s_sat_relu", name), sat0, s0);
        check($sformatf("%s_sat_raw", name), sat1, s1);
        clear_log();
    endtask

    task automatic run_frame(input string name, input logic s0, input logic s1);
        do_start();
        check($sformatf("%s_busy_start", name), busy0, 1);
        check($sformatf("%s_sat_clr", name), sat0, 0);
        for (int i = 0; i < 12; i++) push(vals[i], 0);
        wait_done(name);
        check_frame(name, s0, s1);
    endtask

    initial begin
        #2;
        check("rst_in_ready", if0.in_ready, 0);
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_busy_done_sat", {busy0, done0, sat0}, 0);
        check("rst_addr_data", {if0.out_addr, if0.out_data}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic frame
        vals = '{16'h10, 16'h20, 16'h30, 16'h10, 16'h20, 16'h30,
                 16'h10, 16'h20, 16'h30, 16'h10, 16'h20, 16'h30};
        exp0 = '{16'h60, 16'h60, 16'h60, 16'h60};
        exp1 = exp0;
        run_frame("basic", 1'b0, 1'b0);

        // reset after two accepted results
        do_start();
        push(16'h1000, 0);
        push(16'h2000, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready_valid", {if0.in_ready, if0.out_valid}, 0);
        check("mid_rst_busy_done_sat", {busy0, done0, sat0}, 0);
        check("mid_rst_addr_data", {if0.out_addr, if0.out_data}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_log();
        vals = '{16'h0101, 16'h0202, 16'h0303, 16'h0101, 16'h0202, 16'h0303,
                 16'h0101, 16'h0202, 16'h0303, 16'h0101, 16'h0202, 16'h0303};
        exp0 = '{16'h0606, 16'h0606, 16'h0606, 16'h0606};
        exp1 = exp0;
        run_frame("post_rst", 1'b0, 1'b0);

        // backpressure: write held for 5 cycles, pending PE result must wait
        out_ready = 1'b0;
        do_start();
        push(16'd1, 0); push(16'd2, 0); push(16'd3, 0);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", c), if0.out_valid, 1);
            check($sformatf("bp_addr_data%0d", c), {if0.out_addr, if0.out_data}, {2'd0, 16'd6});
            check($sformatf("bp_in_ready%0d", c), if0.in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 9; i++) push(16'(i % 3 + 1), 0);
        wait_done("bp");
        exp0 = '{16'd6, 16'd6, 16'd6, 16'd6};
        exp1 = exp0;
        check_frame("bp", 1'b0, 1'b0);

        // positive saturation
        vals = '{16'h7000, 16'h7000, 16'h7000, 16'h1, 16'h1, 16'h1,
                 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1};
        exp0 = '{16'h7FFF, 16'h3, 16'h3, 16'h3};
        exp1 = exp0;
        run_frame("sat_pos", 1'b1, 1'b1);

        // negative saturation: raw clamps to 0x8000, ReLU then zeroes it
        vals = '{16'h9000, 16'h9000, 16'h9000, 16'h2, 16'h2, 16'h2,
                 16'h2, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2};
        exp0 = '{16'h0000, 16'h6, 16'h6, 16'h6};
        exp1 = '{16'h8000, 16'h6, 16'h6, 16'h6};
        run_frame("sat_neg", 1'b1, 1'b1);

        // ReLU and exact range limits
        vals = '{16'hFFF0, 16'h0005, 16'h0001, 16'h7FFD, 16'h0001, 16'h0001,
                 16'h8000, 16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'hFFFF};
        exp0 = '{16'h0000, 16'h7FFF, 16'h0000, 16'h02FF};
        exp1 = '{16'hFFF6, 16'h7FFF, 16'h8000, 16'h02FF};
        run_frame("relu", 1'b0, 1'b0);

        // gapped input plus stray starts in ACCUM and EMIT
        vals = '{16'h0011, 16'h0022, 16'h0033, 16'h0100, 16'h0001, 16'h0002,
                 16'h0005, 16'h0006, 16'h0007, 16'h1000, 16'h2000, 16'h0FFF};
        exp0 = '{16'h0066, 16'h0103, 16'h0012, 16'h3FFF};
        exp1 = exp0;
        do_start();
        for (int i = 0; i < 12; i++) begin
            if (i == 4 || i == 9) do_start();
            push(vals[i], i % 3);
        end
        wait_done("stall");
        repeat (5) @(posedge clk);
        #1;
        check("stall_idle_after", busy0, 0);
        check_frame("stall", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pe_output_collector.md
Name: pe_output_collector

Overview:
- Receiving end of the depthwise PE output stream.
- Consumes signed 16-bit per-channel window results from the PE and sums CHANNELS consecutive results into one output pixel.
- Applies saturation and optional ReLU, then writes each pixel to the output feature buffer through a valid/ready write port with an auto-incrementing address.
- Sits between the depthwise PE and the output SRAM; the hardware replacement for bench-side output capture.

Parameters:
- DATA_W, 16, width of PE result and of the written pixel (signed)
- ACC_W, 24, internal accumulator width (signed)
- CHANNELS, 3, PE results summed per output pixel
- NUM_PIXELS, 1024, pixels per frame (32x32)
- ADDR_W, 10, output buffer address width; must satisfy 2^ADDR_W >= NUM_PIXELS
- RELU_EN, 1, 1 = clamp negative results to 0

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- in_valid  in  1  PE result valid
- in_ready  out  1  collector accepts the PE result this cycle
- in_data  in  DATA_W  signed PE window result
- out_valid  out  1  write request to the output buffer
- out_ready  in  1  output buffer accepts the write
- out_addr  out  ADDR_W  pixel address, 0..NUM_PIXELS-1
- out_data  out  DATA_W  saturated / ReLU'd pixel
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse after the last pixel write
- sat_flag  out  1  sticky: a saturation event occurred this frame

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; acc, ch_cnt, pix_cnt cleared.
  - in_ready, out_valid, busy, done, sat_flag all 0; out_addr=0; out_data=0.
- FSM states are IDLE, ACCUM, EMIT, DONE.
- IDLE:
  - in_ready=0.
  - start=1: clear acc, ch_cnt, pix_cnt and sat_flag, go to ACCUM.
  - start while not in IDLE is ignored.
- ACCUM:
  - in_ready=1.
  - Each handshake (in_valid & in_ready): acc <= acc + sign_ext(in_data), ch_cnt increments.
  - On the handshake with ch_cnt==CHANNELS-1: register the final sum into out_data, set out_addr=pix_cnt, reset acc and ch_cnt to 0, go to EMIT.
  - in_valid=0 stalls the state with no change.
- Saturation and ReLU (applied to the final sum):
  - Sum above 2^(DATA_W-1)-1 gives 0x7FFF and sets sat_flag.
  - Sum below -2^(DATA_W-1) gives 0x8000 and sets sat_flag.
  - Then, if RELU_EN=1 and the result is negative, the result is 0. ReLU alone does not set sat_flag.
- EMIT:
  - out_valid=1, in_ready=0.
  - out_data and out_addr are held stable until out_ready=1.
  - On out_valid & out_ready: pix_cnt increments. If pix_cnt was NUM_PIXELS-1, go to DONE; otherwise return to ACCUM.
  - out_valid drops the cycle after the handshake.
- DONE:
  - done=1 for exactly one cycle; busy falls the same cycle.
  - Next state is IDLE. sat_flag holds until the next start.
- Latency and throughput:
  - out_valid rises 1 cycle after the last channel handshake.
  - Minimum CHANNELS+1 cycles per pixel, because there is no overlap between EMIT and ACCUM.
- Widths: ACC_W must be at least DATA_W + ceil(log2(CHANNELS)); the accumulator itself never wraps.
- Address: out_addr is never advanced past NUM_PIXELS-1; there is no wrap within a frame.
- Reset mid-frame: all progress is discarded; the next frame requires a new start.

Test Plan:
(CHANNELS=3, NUM_PIXELS=4, RELU_EN=1 unless stated)
- Reset behaviour: assert rst=0 mid-ACCUM after 2 results accepted -> all outputs 0 immediately; after release plus start, the first pixel sums only new inputs.
- Basic frame: start, feed 12 results 0x0010,0x0020,0x0030 repeated, out_ready=1 -> writes addr 0..3 with data 0x0060 each, then done pulse, busy falls, sat_flag=0.
- Backpressure: out_ready=0 for 5 cycles during EMIT -> out_valid, out_addr, out_data stable; in_ready=0; in_valid results not consumed; write completes when out_ready=1.
- Saturation: inputs 0x7000,0x7000,0x7000 -> out_data=0x7FFF, sat_flag=1 through the frame end. Inputs 0x9000 x3 with RELU_EN=0 -> 0x8000, sat_flag=1.
- ReLU: inputs 0xFFF0,0x0005,0x0001 (sum -10) -> out_data=0x0000, sat_flag unchanged.
- Stalls and stray start: in_valid toggling with gaps, plus start pulsed mid-frame -> sums correct, start ignored, exactly 4 writes and 1 done.
